tmr_vote_monitor: RTL

- Parametrised N-channel majority voter with registered error monitoring; successor to the single-bit voter with a flat OR of per-instance error wires.
- Each channel receives three replicas (A, B, C) of a bit, outputs the registered majority value and flags any disagreement.
- Per-channel sticky flags, a saturating event counter, a channel mask and a clear handshake allow slow-control readout without losing events.
- Sits between triplicated logic and the slow-control/status register bank.

---
 rtl/tmr_vote_monitor.sv | 116 +++++++++++
 1 files changed

// File: rtl/tmr_vote_monitor.sv
// N-channel triple-modular-redundancy voter with sticky error flags, saturating event counter and clear handshake.
// Optional first-failure capture is enabled by defining TMR_VOTE_MONITOR_FIRST_CAPTURE_EN.
module tmr_vote_monitor #(
    parameter int N     = 10,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     inA,
    input  logic [N-1:0]     inB,
    input  logic [N-1:0]     inC,
    input  logic [N-1:0]     chMask,
    output logic [N-1:0]     outVoted,
    output logic             tmrError,
    output logic [N-1:0]     errFlags,
    output logic [CNT_W-1:0] errCount,
    input  logic             clrReq,
    output logic             clrAck,
    output logic [5:0]       firstIdx,
    output logic             firstValid
);

    typedef enum logic [1:0] {IDLE, CLEAR, ACK, WAIT} clrState_t;

    clrState_t        stateReg, stateNext;
    logic [N-1:0]     maj, mis, umis;
    logic             anyErr, inClear;
    logic [N-1:0]     outVotedReg, errFlagsReg, flagsBase;
    logic             tmrErrorReg, clrAckReg;
    logic [CNT_W-1:0] errCountReg, countBase, countNext;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : gChannel
            assign maj[gi] = (inA[gi] & inB[gi]) | (inB[gi] & inC[gi]) | (inA[gi] & inC[gi]);
            assign mis[gi] = (inA[gi] ^ inB[gi]) | (inB[gi] ^ inC[gi]);
        end
    endgenerate

    assign umis    = mis & ~chMask;
    assign anyErr  = |umis;
    assign inClear = (stateReg == CLEAR);

    // Errors arriving during the clear cycle are merged into the freshly cleared state.
    assign flagsBase = inClear ? '0 : errFlagsReg;
    assign countBase = inClear ? '0 : errCountReg;
    assign countNext = (&countBase) ? countBase : countBase + CNT_W'(anyErr);

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (clrReq) stateNext = CLEAR;
            CLEAR:   stateNext = ACK;
            ACK:     stateNext = WAIT;
            WAIT:    if (!clrReq) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg    <= IDLE;
            outVotedReg <= '0;
            tmrErrorReg <= 1'b0;
            errFlagsReg <= '0;
            errCountReg <= '0;
            clrAckReg   <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            outVotedReg <= maj;
            tmrErrorReg <= anyErr;
            errFlagsReg <= flagsBase | umis;
            errCountReg <= countNext;
            clrAckReg   <= (stateNext == ACK);
        end
    end

    assign outVoted = outVotedReg;
    assign tmrError = tmrErrorReg;
    assign errFlags = errFlagsReg;
    assign errCount = errCountReg;
    assign clrAck   = clrAckReg;

`ifdef TMR_VOTE_MONITOR_FIRST_CAPTURE_EN
    logic [5:0] lowIdx, firstIdxReg;
    logic       firstValidReg;

    always_comb begin
        lowIdx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (umis[j]) lowIdx = 6'(j);
        end
    end

    // A new capture in the clear cycle wins over the clear itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            firstIdxReg   <= '0;
            firstValidReg <= 1'b0;
        end else if (anyErr && (inClear || !firstValidReg)) begin
            firstIdxReg   <= lowIdx;
            firstValidReg <= 1'b1;
        end else if (inClear) begin
            firstIdxReg   <= '0;
            firstValidReg <= 1'b0;
        end
    end

    assign firstIdx   = firstIdxReg;
    assign firstValid = firstValidReg;
`else
    assign firstIdx   = '0;
    assign firstValid = 1'b0;
`endif

endmodule
